// File: rtl/fp_addsub_pipe_if.sv
// fp_addsub_pipe_if: operand/result handshake bundle for the pipelined FP adder
interface fp_addsub_pipe_if #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
);
    localparam int W = 1 + EXP_W + MAN_W;
    logic in_valid;
    logic in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic op;
    logic out_valid;
    logic out_ready;
    logic [W-1:0] out_sum;
    logic [1:0] out_flag;
    modport master (
        output in_valid, in_a, in_b, op, out_ready,
        input in_ready, out_valid, out_sum, out_flag
    );
    modport slave (
        input in_valid, in_a, in_b, op, out_ready,
        output in_ready, out_valid, out_sum, out_flag
    );
endinterface

// File: rtl/fp_addsub_pipe.sv
// fp_addsub_pipe: 3-stage pipelined floating-point adder/subtractor with RNE rounding
// Stages: unpack/swap, align/add, normalise/round/pack; all stages advance together.
module fp_addsub_pipe #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
) (
    input logic clk,
    input logic rst_n,
    fp_addsub_pipe_if.slave bus
);
    localparam int W = 1 + EXP_W + MAN_W;
    localparam int M = MAN_W + 4;
    localparam int XW = EXP_W + 2;
    localparam int LW = $clog2(M + 1);
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W - 1){1'b0}}};
    localparam logic signed [XW-1:0] EMAX = XW'((1 << EXP_W) - 1);

    logic adv;
    logic sa, sb, za, zb, xa, xb, swap;
    logic [W-2:0] big, sml;
    logic [W-1:0] sres;
    logic s1_v, s1_spec, s1_s, s1_sub;
    logic [W-1:0] s1_res;
    logic [1:0] s1_flag;
    logic [EXP_W-1:0] s1_e, s1_d;
    logic [MAN_W-1:0] s1_ma, s1_mb;
    logic [M-1:0] ma, mb, bsh, bal;
    logic stk;
    logic [M:0] sum;
    logic s2_v, s2_spec, s2_s;
    logic [W-1:0] s2_res;
    logic [1:0] s2_flag;
    logic [EXP_W-1:0] s2_e;
    logic [M:0] s2_sum;
    logic cy, up;
    logic [LW-1:0] lz;
    logic [M-1:0] n;
    logic [MAN_W:0] rnd;
    logic signed [XW-1:0] ef;
    logic [W-1:0] res;
    logic [1:0] flag;

    assign adv = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = adv;

    always_comb begin
        sa = bus.in_a[W-1];
        sb = bus.in_b[W-1] ^ bus.op;
        za = bus.in_a[W-2:MAN_W] == '0;
        zb = bus.in_b[W-2:MAN_W] == '0;
        xa = &bus.in_a[W-2:MAN_W];
        xb = &bus.in_b[W-2:MAN_W];
        swap = bus.in_b[W-2:0] > bus.in_a[W-2:0];
        big = swap ? bus.in_b[W-2:0] : bus.in_a[W-2:0];
        sml = swap ? bus.in_a[W-2:0] : bus.in_b[W-2:0];
        // zero and special outcomes are settled up front and ride past the datapath
        sres = (xa || xb) ? QNAN : (za && zb) ? {sa & sb, {(W - 1){1'b0}}} :
               za ? {sb, bus.in_b[W-2:0]} : {sa, bus.in_a[W-2:0]};
    end

    always_comb begin
        ma = {1'b1, s1_ma, 3'b000};
        mb = {1'b1, s1_mb, 3'b000};
        bsh = mb >> s1_d;
        stk = |(mb & ~({M{1'b1}} << s1_d));
        bal = {bsh[M-1:1], bsh[0] | stk};
        sum = s1_sub ? {1'b0, ma} - {1'b0, bal} : {1'b0, ma} + {1'b0, bal};
    end

    always_comb begin
        cy = s2_sum[M];
        lz = LW'(M);
        for (int i = 0; i < M; i++) lz = s2_sum[i] ? LW'(M - 1 - i) : lz;
        n = cy ? {s2_sum[M:2], s2_sum[1] | s2_sum[0]} : s2_sum[M-1:0] << lz;
        up = n[2] & (n[1] | n[0] | n[3]);
        rnd = {1'b0, n[M-2:3]} + (MAN_W + 1)'(up);
        // n[M-1] is the normalised hidden bit; it is clear only on exact cancellation
        ef = XW'(s2_e) + (cy ? XW'(1) : -XW'(lz)) + XW'(rnd[MAN_W]);
        res = s2_spec ? s2_res : !n[M-1] ? '0 :
              (ef >= EMAX) ? {s2_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}} :
              (ef[XW-1] || ef == '0) ? '0 : {s2_s, ef[EXP_W-1:0], rnd[MAN_W-1:0]};
        flag = s2_spec ? s2_flag : !n[M-1] ? 2'b00 : (ef >= EMAX) ? 2'b01 :
               (ef[XW-1] || ef == '0) ? 2'b10 : 2'b00;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v <= 1'b0;
            s1_spec <= 1'b0;
            s1_res <= '0;
            s1_flag <= '0;
            s1_s <= 1'b0;
            s1_sub <= 1'b0;
            s1_e <= '0;
            s1_d <= '0;
            s1_ma <= '0;
            s1_mb <= '0;
            s2_v <= 1'b0;
            s2_spec <= 1'b0;
            s2_res <= '0;
            s2_flag <= '0;
            s2_s <= 1'b0;
            s2_e <= '0;
            s2_sum <= '0;
            bus.out_valid <= 1'b0;
            bus.out_sum <= '0;
            bus.out_flag <= '0;
        end else if (adv) begin
            s1_v <= bus.in_valid;
            s1_spec <= xa | xb | za | zb;
            s1_res <= sres;
            s1_flag <= {2{xa | xb}};
            s1_s <= swap ? sb : sa;
            s1_sub <= sa ^ sb;
            s1_e <= big[W-2:MAN_W];
            s1_d <= big[W-2:MAN_W] - sml[W-2:MAN_W];
            s1_ma <= big[MAN_W-1:0];
            s1_mb <= sml[MAN_W-1:0];
            s2_v <= s1_v;
            s2_spec <= s1_spec;
            s2_res <= s1_res;
            s2_flag <= s1_flag;
            s2_s <= s1_s;
            s2_e <= s1_e;
            s2_sum <= sum;
            bus.out_valid <= s2_v;
            bus.out_sum <= res;
            bus.out_flag <= flag;
        end
    end
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// tb_fp_addsub_pipe: random and directed checks of the FP adder against an exact-arithmetic model
module tb_fp_addsub_pipe;
    logic clk = 1'b0;
    logic rst_n;
    int checks = 0;
    int failures = 0;
    int h_outs = 0;
    logic done;
    logic [17:0] hq[$];

    always #5 clk = ~clk;

    fp_addsub_pipe_if #(.EXP_W(5), .MAN_W(10)) h_if ();
    fp_addsub_pipe_if #(.EXP_W(8), .MAN_W(23)) s_if ();

    fp_addsub_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (.clk(clk), .rst_n(rst_n), .bus(h_if.slave));
    fp_addsub_pipe #(.EXP_W(8), .MAN_W(23)) dut_s (.clk(clk), .rst_n(rst_n), .bus(s_if.slave));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // exact real sum in wide integers, then rounded to nearest-even; subnormals count as zero
    function automatic logic [17:0] ref_add(input logic [15:0] a, input logic [15:0] b, input logic o);
        logic sa, sb, neg;
        int ea, eb, p, e, sh;
        longint va, vb, s, m, q, rem, half;
        sa = a[15];
        sb = b[15] ^ o;
        ea = int'(a[14:10]);
        eb = int'(b[14:10]);
        if (ea == 31 || eb == 31) return {2'b11, 16'h7E00};
        if (ea == 0 && eb == 0) return {2'b00, sa & sb, 15'h0000};
        if (ea == 0) return {2'b00, sb, b[14:0]};
        if (eb == 0) return {2'b00, sa, a[14:0]};
        va = longint'({1'b1, a[9:0]}) << (ea - 1);
        vb = longint'({1'b1, b[9:0]}) << (eb - 1);
        s = (sa ? -va : va) + (sb ? -vb : vb);
        if (s == 0) return 18'h00000;
        neg = s < 0;
        m = neg ? -s : s;
        p = 0;
        for (int i = 0; i < 63; i++) if (m[i]) p = i;
        e = p - 9;
        if (p > 10) begin
            sh = p - 10;
            q = m >> sh;
            rem = m - (q << sh);
            half = longint'(1) << (sh - 1);
            if (rem > half || (rem == half && q[0])) q = q + 1;
        end else q = m << (10 - p);
        if (q == 2048) begin
            q = 1024;
            e = e + 1;
        end
        if (e >= 31) return {2'b01, neg, 5'h1F, 10'h000};
        if (e <= 0) return {2'b10, 16'h0000};
        return {2'b00, neg, e[4:0], q[9:0]};
    endfunction

    function automatic int rexp();
        int r;
        r = int'($urandom_range(0, 15));
        return (r == 0) ? 0 : (r == 1) ? 31 : int'($urandom_range(1, 30));
    endfunction

    function automatic logic [15:0] rh(input int e);
        return {1'($urandom_range(0, 1)), 5'(e), 10'($urandom_range(0, 1023))};
    endfunction

    always @(negedge clk) begin
        if (!rst_n) hq.delete();
        else begin
            if (h_if.out_valid && h_if.out_ready) begin
                if (hq.size() == 0) check("h_extra", 64'(hq.size()), 64'd1);
                else check("h_model", {h_if.out_flag, h_if.out_sum}, hq.pop_front());
                h_outs++;
            end
            if (h_if.in_valid && h_if.in_ready) hq.push_back(ref_add(h_if.in_a, h_if.in_b, h_if.op));
        end
    end

    task automatic h_send(input logic [15:0] a, input logic [15:0] b, input logic o);
        int n = 0;
        logic acc;
        h_if.in_valid = 1'b1;
        h_if.in_a = a;
        h_if.in_b = b;
        h_if.op = o;
        do begin
            @(negedge clk);
            acc = h_if.in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 200);
        if (!acc) check("accept_timeout", 64'(acc), 64'd1);
        h_if.in_valid = 1'b0;
    endtask

    task automatic h_dir(input string tag, input logic [15:0] a, input logic [15:0] b, input logic o,
                         input logic [15:0] es, input logic [1:0] ef);
        int n = 0;
        h_send(a, b, o);
        do begin
            @(negedge clk);
            n++;
        end while (!h_if.out_valid && n < 20);
        check({tag, "_lat"}, 64'(n), 64'd3);
        check(tag, {h_if.out_flag, h_if.out_sum}, {ef, es});
        @(posedge clk);
        #1;
    endtask

    task automatic s_dir(input string tag, input logic [31:0] a, input logic [31:0] b, input logic o,
                         input logic [31:0] es, input logic [1:0] ef);
        int n = 0;
        s_if.in_valid = 1'b1;
        s_if.in_a = a;
        s_if.in_b = b;
        s_if.op = o;
        @(posedge clk);
        #1;
        s_if.in_valid = 1'b0;
        do begin
            @(negedge clk);
            n++;
        end while (!s_if.out_valid && n < 20);
        check({tag, "_lat"}, 64'(n), 64'd3);
        check(tag, {s_if.out_flag, s_if.out_sum}, {ef, es});
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int base, n, n_ov;
        logic [17:0] held;
        rst_n = 1'b0;
        done = 1'b0;
        h_if.in_valid = 1'b0;
        h_if.in_a = '0;
        h_if.in_b = '0;
        h_if.op = 1'b0;
        h_if.out_ready = 1'b1;
        s_if.in_valid = 1'b0;
        s_if.in_a = '0;
        s_if.in_b = '0;
        s_if.op = 1'b0;
        s_if.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(h_if.out_valid), 64'd0);
        check("rst_out_sum", 64'(h_if.out_sum), 64'd0);
        check("rst_out_flag", 64'(h_if.out_flag), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", 64'(h_if.in_ready), 64'd1);

        h_dir("one_plus_one", 16'h3C00, 16'h3C00, 1'b0, 16'h4000, 2'b00);
        h_dir("one_minus_one", 16'h3C00, 16'h3C00, 1'b1, 16'h0000, 2'b00);
        h_dir("rne_tie_even", 16'h3C00, 16'h1000, 1'b0, 16'h3C00, 2'b00);
        h_dir("rne_tie_odd", 16'h3C01, 16'h1000, 1'b0, 16'h3C02, 2'b00);
        h_dir("overflow", 16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 2'b01);
        h_dir("underflow", 16'h0401, 16'h0400, 1'b1, 16'h0000, 2'b10);
        h_dir("nan_in", 16'h7E00, 16'h3C00, 1'b0, 16'h7E00, 2'b11);
        h_dir("zero_a", 16'h0000, 16'hC000, 1'b0, 16'hC000, 2'b00);
        h_dir("zero_b", 16'h3C00, 16'h0000, 1'b1, 16'h3C00, 2'b00);

        h_if.out_ready = 1'b0;
        base = h_outs;
        fork
            begin
                for (int i = 0; i < 4; i++)
                    h_send(rh(int'($urandom_range(1, 30))), rh(int'($urandom_range(1, 30))), 1'($urandom_range(0, 1)));
            end
            begin
                int m = 0;
                do begin
                    @(negedge clk);
                    m++;
                end while (!h_if.out_valid && m < 20);
                held = {h_if.out_flag, h_if.out_sum};
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    check("bp_in_ready", 64'(h_if.in_ready), 64'd0);
                    check("bp_hold", {h_if.out_flag, h_if.out_sum}, 64'(held));
                end
                @(posedge clk);
                #1;
                h_if.out_ready = 1'b1;
            end
        join
        repeat (10) @(posedge clk);
        #1;
        check("bp_count", 64'(h_outs - base), 64'd4);
        check("bp_drain", 64'(hq.size()), 64'd0);

        for (int i = 0; i < 3; i++) h_send(16'h3C00 + 16'(i), 16'h4000, 1'b0);
        check("rst_mid_pre", 64'(h_if.out_valid), 64'd1);
        base = h_outs;
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_out_valid", 64'(h_if.out_valid), 64'd0);
        check("rst_mid_out_sum", 64'(h_if.out_sum), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        n_ov = 0;
        repeat (8) begin
            @(negedge clk);
            if (h_if.out_valid) n_ov++;
        end
        check("rst_no_stale", 64'(n_ov), 64'd0);
        check("rst_no_outs", 64'(h_outs - base), 64'd0);
        @(posedge clk);
        #1;

        base = h_outs;
        fork
            begin
                for (int i = 0; i < 400; i++) begin
                    int ea, eb;
                    logic [15:0] a, b;
                    ea = rexp();
                    eb = ($urandom_range(0, 1) == 1) ? rexp() : ea + int'($urandom_range(0, 4)) - 2;
                    if (eb < 0) eb = 0;
                    if (eb > 31) eb = 31;
                    a = rh(ea);
                    b = rh(eb);
                    if ($urandom_range(0, 15) == 0) b = a;
                    h_send(a, b, 1'($urandom_range(0, 1)));
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    h_if.out_ready = ($urandom_range(0, 3) != 0);
                end
                h_if.out_ready = 1'b1;
            end
        join
        n = 0;
        while (hq.size() != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("rand_drain", 64'(hq.size()), 64'd0);
        check("rand_count", 64'(h_outs - base), 64'd400);

        s_dir("sp_one_plus_one", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 2'b00);
        s_dir("sp_one_minus_two", 32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 2'b00);
        s_dir("sp_overflow", 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 2'b01);
        s_dir("sp_nan", 32'h7F800000, 32'h3F800000, 1'b0, 32'h7FC00000, 2'b11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fp_addsub_pipe.md
Name: fp_addsub_pipe

Overview:
Parametrised, 3-stage pipelined IEEE-754-style floating-point adder/subtractor. It generalises the half-precision adder to any exponent/mantissa width. It adds round-to-nearest-even with guard/round/sticky bits and a valid/ready handshake on both sides. It sits in the fp_alu datapath between operand issue and result writeback.

Parameters:
EXP_W, 5, exponent field width (bias = 2^(EXP_W-1)-1)
MAN_W, 10, stored mantissa width (hidden bit implied)
W, 1+EXP_W+MAN_W, derived operand width; not overridable

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand pair valid
in_ready  output  1  block accepts operands this cycle
in_a  input  W  operand A
in_b  input  W  operand B
op  input  1  0 = A+B, 1 = A-B (B sign inverted)
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_sum  output  W  result
out_flag  output  2  00 ok, 01 overflow, 10 underflow, 11 invalid/NaN

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset clears all stage valid bits, out_valid=0, out_sum=0 and out_flag=00. in_ready=1 from the first cycle after deassertion.
- In-flight operations are discarded on reset and never emerge.
- Global advance: adv = !out_valid | out_ready; in_ready = adv.
- Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
- All stage registers load only when adv=1.
- Latency is exactly 3 cycles from accept to out_valid with no stall. Throughput is 1 per cycle.
- Bubbles are not collapsed.
- While out_valid & !out_ready, out_sum and out_flag hold stable and in_ready=0.
- Stage 1, unpack/classify:
  - The B sign is XORed with op.
  - exp==0 marks an operand as zero; subnormals are flushed to zero.
  - exp all-ones marks an operand as special (inf or NaN).
  - Operands are swapped so A has the larger magnitude (compare exp, then mantissa).
  - d = eA-eB is computed unsigned, with EXP_W bits.
- Stage 2, align/add:
  - The mantissas are {1,man,G,R,S}.
  - B is right-shifted by d; bits shifted out OR into S.
  - If d > MAN_W+3, B reduces to sticky only.
  - The block adds the mantissas when signs are equal and subtracts (A-B, never negative) otherwise.
  - The result sign is sign(A).
- Stage 3, normalise/round/pack:
  - On a carry-out, shift right by 1 (LSB ORed into sticky) and increment exp.
  - Otherwise, a leading-zero count shifts left and exp is decremented by that count.
  - Round-to-nearest-even: increment when G & (R|S|LSB).
  - A rounding carry renormalises (exp+1).
- Specials, in priority order:
  1. Any special operand: out_sum = canonical NaN (sign 0, exp all-ones, mantissa MSB 1, rest 0), flag 11.
  2. Both zero: sign = AND of effective signs, exp/man 0, flag 00.
  3. One zero: the other operand, with its effective sign, flag 00.
  4. Exact cancellation: +0, flag 00.
  5. Final exp >= all-ones: ±inf (exp all-ones, man 0), flag 01.
  6. Final exp <= 0: +0, flag 10.
- Exponent arithmetic is carried in EXP_W+2 signed bits so overflow and underflow are detected without wrap.

Test Plan:
- 16'h3C00 + 16'h3C00, op=0 -> 16'h4000, flag 00, out_valid exactly 3 cycles after accept; 16'h3C00 - 16'h3C00, op=1 -> 16'h0000, flag 00.
- RNE ties: 16'h3C00 + 16'h1000 -> 16'h3C00; 16'h3C01 + 16'h1000 -> 16'h3C02; flag 00 for both.
- Overflow/underflow: 16'h7BFF + 16'h7BFF -> 16'h7C00, flag 01; 16'h0401 - 16'h0400 -> 16'h0000, flag 10.
- Specials: 16'h7E00 + 16'h3C00 -> 16'h7E00, flag 11; 16'h0000 + 16'hC000 -> 16'hC000, flag 00; 16'h3C00 - 16'h0000 -> 16'h3C00.
- Back-pressure: issue 4 back-to-back ops with out_ready held low for 5 cycles -> in_ready=0 and out_sum stable throughout; all 4 results then emerge in order with none lost or duplicated. Assert rst_n mid-stream -> out_valid=0 immediately and no stale result afterwards.
- EXP_W=8, MAN_W=23: 32'h3F800000 + 32'h3F800000 -> 32'h40000000; 32'h3F800000 - 32'h40000000 -> 32'hBF800000, flag 00.
